adc_spi_reader: RTL and testbench

ADC_SPI_READER -- requirements
Module: adc_spi_reader

---
 rtl/adc_spi_reader.sv | 235 +++++++++++++++++++++++
 tb/tb_adc_spi_reader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_reader.sv
// adc_spi_reader: SPI register reader for an ADC serial control port.
// A start request sends a 16-bit frame (8-bit address, 8-bit data) MSB first
// and captures the ADC readback during the data half of the frame.
// Optional feature macro: ADC_RD_AUTO_READOUT_EN -- wraps the read frame in a
// write 0x0001 / write 0x0000 pair, separated by SEN-high gaps.
module adc_spi_reader #(
  parameter int unsigned HALF_DIV = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] addr,
  output logic       spi_sen,
  output logic       spi_sclk,
  output logic       spi_sdat,
  input  logic       spi_sdout,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done
);

`ifdef ADC_RD_AUTO_READOUT_EN
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;
`endif

  localparam logic [7:0] RELOAD = 8'(HALF_DIV - 1);

  state_t      state, state_nx;
  logic [7:0]  half_cnt, half_nx;
  logic [3:0]  bit_cnt, bit_nx;
  logic        phase, phase_nx;   // 0: SCLK-high half, 1: SCLK-low half
  logic [7:0]  addr_q;
  logic [7:0]  addr_src;
  logic [7:0]  shift_q;
  logic [15:0] word_nx;
  logic        half_end;
  logic        read_frame;
  logic        sen_d, sclk_d, sdat_d, busy_d, done_d;

`ifdef ADC_RD_AUTO_READOUT_EN
  logic [1:0]  frame_idx, frame_nx;
`endif

  assign half_end = (half_cnt == 8'd0);

  // The address is registered on the start cycle, but the first SDAT bit is
  // driven from that same cycle, so the live input is used while still idle.
  assign addr_src = (state == IDLE) ? addr : addr_q;

  // Frame word seen by the output stage (indexed by the next frame number).
  always_comb begin
`ifdef ADC_RD_AUTO_READOUT_EN
    case (frame_nx)
      2'd0:    word_nx = 16'h0001;
      2'd1:    word_nx = {addr_src, 8'h00};
      default: word_nx = 16'h0000;
    endcase
    read_frame = (frame_idx == 2'd1);
`else
    word_nx    = {addr_src, 8'h00};
    read_frame = 1'b1;
`endif
  end

  // State and counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      phase    <= 1'b0;
`ifdef ADC_RD_AUTO_READOUT_EN
      frame_idx <= '0;
`endif
    end else begin
      state    <= state_nx;
      half_cnt <= half_nx;
      bit_cnt  <= bit_nx;
      phase    <= phase_nx;
`ifdef ADC_RD_AUTO_READOUT_EN
      frame_idx <= frame_nx;
`endif
    end
  end

  // Next-state and next-counter logic.
  always_comb begin
    state_nx = state;
    half_nx  = half_cnt;
    bit_nx   = bit_cnt;
    phase_nx = phase;
`ifdef ADC_RD_AUTO_READOUT_EN
    frame_nx = frame_idx;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SETUP;
          half_nx  = RELOAD;
          bit_nx   = '0;
          phase_nx = 1'b0;
`ifdef ADC_RD_AUTO_READOUT_EN
          frame_nx = '0;
`endif
        end
      end
      SETUP: begin
        if (half_end) begin
          state_nx = SHIFT;
          half_nx  = RELOAD;
          bit_nx   = '0;
          phase_nx = 1'b0;
        end else begin
          half_nx = half_cnt - 8'd1;
        end
      end
      SHIFT: begin
        if (half_end) begin
          half_nx = RELOAD;
          if (!phase) begin
            phase_nx = 1'b1;
          end else begin
            phase_nx = 1'b0;
            bit_nx   = bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) state_nx = HOLD;
          end
        end else begin
          half_nx = half_cnt - 8'd1;
        end
      end
      HOLD: begin
        if (half_end) begin
`ifdef ADC_RD_AUTO_READOUT_EN
          if (frame_idx != 2'd2) begin
            state_nx = GAP;
            half_nx  = RELOAD;
            phase_nx = 1'b0;
            frame_nx = frame_idx + 2'd1;
          end else begin
            state_nx = DONE;
            half_nx  = '0;
          end
`else
          state_nx = DONE;
          half_nx  = '0;
`endif
        end else begin
          half_nx = half_cnt - 8'd1;
        end
      end
`ifdef ADC_RD_AUTO_READOUT_EN
      GAP: begin
        if (half_end) begin
          half_nx = RELOAD;
          if (!phase) begin
            phase_nx = 1'b1;
          end else begin
            phase_nx = 1'b0;
            state_nx = SETUP;
          end
        end else begin
          half_nx = half_cnt - 8'd1;
        end
      end
`endif
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode from the next state so the registered pins line up with it.
  always_comb begin
    sen_d  = 1'b1;
    sclk_d = 1'b1;
    sdat_d = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_nx)
      SETUP: begin
        sen_d  = 1'b0;
        busy_d = 1'b1;
        sdat_d = word_nx[15];
      end
      SHIFT: begin
        sen_d  = 1'b0;
        busy_d = 1'b1;
        sclk_d = ~phase_nx;
        sdat_d = word_nx[4'd15 - bit_nx];
      end
      HOLD: begin
        sen_d  = 1'b0;
        busy_d = 1'b1;
      end
`ifdef ADC_RD_AUTO_READOUT_EN
      GAP:  busy_d = 1'b1;
`endif
      DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  // Registered serial pins and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_sen  <= 1'b1;
      spi_sclk <= 1'b1;
      spi_sdat <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      spi_sen  <= sen_d;
      spi_sclk <= sclk_d;
      spi_sdat <= sdat_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Address capture, readback shifting and result update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      shift_q <= '0;
      rdata   <= '0;
    end else begin
      if (state == IDLE && start) addr_q <= addr;
      if (state == SHIFT && phase && half_end && bit_cnt[3] && read_frame)
        shift_q <= {shift_q[6:0], spi_sdout};
      if (state_nx == DONE) rdata <= shift_q;
    end
  end

endmodule

// File: tb/tb_adc_spi_reader.sv
// tb_adc_spi_reader: scoreboard bench for adc_spi_reader (HALF_DIV 32 and 2).
module tb_adc_spi_reader;

  localparam int unsigned HD  = 32;
  localparam int unsigned HD2 = 2;
`ifdef ADC_RD_AUTO_READOUT_EN
  localparam int unsigned NFR = 3;
  localparam int unsigned UNITS = 106;
`else
  localparam int unsigned NFR = 1;
  localparam int unsigned UNITS = 34;
`endif

  typedef struct {
    logic [7:0] rd;
    logic [7:0] ab;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       start = 1'b0, start2 = 1'b0;
  logic [7:0] addr = 8'h00, addr2 = 8'h00;
  logic       spi_sen, spi_sclk, spi_sdat, busy, done;
  logic       sen2, sclk2, sdat2, busy2, done2;
  logic       sdout = 1'b0, sdout2 = 1'b0;
  logic [7:0] rdata, rdata2;
  logic [7:0] resp = 8'h00, resp2 = 8'h00;

  adc_spi_reader #(.HALF_DIV(HD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr),
    .spi_sen(spi_sen), .spi_sclk(spi_sclk), .spi_sdat(spi_sdat),
    .spi_sdout(sdout), .rdata(rdata), .busy(busy), .done(done)
  );

  adc_spi_reader #(.HALF_DIV(HD2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .addr(addr2),
    .spi_sen(sen2), .spi_sclk(sclk2), .spi_sdat(sdat2),
    .spi_sdout(sdout2), .rdata(rdata2), .busy(busy2), .done(done2)
  );

  exp_t q[$];
  exp_t q2[$];
  int unsigned n_pass = 0, n_total = 0;
  int unsigned cyc = 0;
  int unsigned n_done = 0, n_done2 = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
  endtask

  function automatic logic [7:0] exp_addr(input logic [7:0] a);
`ifdef ADC_RD_AUTO_READOUT_EN
    return 8'h00;
`else
    return a;
`endif
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Responder + monitor for the HALF_DIV=32 instance.
  initial begin : mon1
    logic p_sen, p_sclk, p_busy;
    int unsigned t0, sen_low, rises, fall, nfr;
    logic [7:0] ab;
    exp_t e;
    p_sen = 1'b1; p_sclk = 1'b1; p_busy = 1'b0;
    t0 = 0; sen_low = 0; rises = 0; fall = 0; nfr = 0; ab = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (busy && !p_busy) begin
          t0 = cyc; sen_low = 0; rises = 0; nfr = 0;
        end
        if (p_sen && !spi_sen) begin
          fall = 0;
          nfr++;
        end
        if (!spi_sen) begin
          sen_low++;
          if (!p_sclk && spi_sclk) rises++;
          if (p_sclk && !spi_sclk) begin
            if (nfr == 1 && fall < 8) ab[7-fall] = spi_sdat;
            sdout = (fall >= 8 && fall < 16) ? resp[15-fall] : 1'b1;
            fall++;
          end
        end
        if (done) begin
          n_done++;
          if (q.size() == 0) begin
            n_total++;
            $display("FAIL done_without_request: got done pulse, expected none");
          end else begin
            e = q.pop_front();
            check("rdata", rdata, e.rd);
            check("addr_bits", ab, e.ab);
            check("latency", cyc - t0, UNITS * HD);
            check("sen_low_cycles", sen_low, NFR * 34 * HD);
            check("sclk_rises", rises, 16 * NFR);
          end
        end
      end
      p_sen = spi_sen; p_sclk = spi_sclk; p_busy = busy;
    end
  end

  // Responder + monitor for the HALF_DIV=2 instance.
  initial begin : mon2
    logic p_sen, p_sclk, p_busy;
    int unsigned t0, rises, fall, nfr;
    logic [7:0] ab;
    exp_t e;
    p_sen = 1'b1; p_sclk = 1'b1; p_busy = 1'b0;
    t0 = 0; rises = 0; fall = 0; nfr = 0; ab = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (busy2 && !p_busy) begin
          t0 = cyc; rises = 0; nfr = 0;
        end
        if (p_sen && !sen2) begin
          fall = 0;
          nfr++;
        end
        if (!sen2) begin
          if (!p_sclk && sclk2) rises++;
          if (p_sclk && !sclk2) begin
            if (nfr == 1 && fall < 8) ab[7-fall] = sdat2;
            sdout2 = (fall >= 8 && fall < 16) ? resp2[15-fall] : 1'b1;
            fall++;
          end
        end
        if (done2) begin
          n_done2++;
          if (q2.size() == 0) begin
            n_total++;
            $display("FAIL done2_without_request: got done pulse, expected none");
          end else begin
            e = q2.pop_front();
            check("hd2_rdata", rdata2, e.rd);
            check("hd2_addr_bits", ab, e.ab);
            check("hd2_latency", cyc - t0, UNITS * HD2);
            check("hd2_sclk_rises", rises, 16 * NFR);
          end
        end
      end
      p_sen = sen2; p_sclk = sclk2; p_busy = busy2;
    end
  end

  task automatic wait_done(input int unsigned nd, input int unsigned limit);
    int unsigned k = 0;
    while (n_done == nd && k < limit) begin
      @(posedge clk);
      k++;
    end
    if (n_done == nd) begin
      n_total++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected one", limit);
    end
  endtask

  task automatic pulse_start(input logic [7:0] a);
    @(negedge clk);
    start = 1'b1;
    addr  = a;
    @(negedge clk);
    start = 1'b0;
    addr  = 8'h00;
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] r);
    int unsigned nd;
    resp = r;
    q.push_back('{r, exp_addr(a)});
    nd = n_done;
    pulse_start(a);
    wait_done(nd, UNITS * HD + 200);
    repeat (3) @(negedge clk);
  endtask

  initial begin : stim
    logic [7:0] va[3];
    logic [7:0] vr[3];
    int unsigned nd, k;
    va = '{8'h3D, 8'h80, 8'hFF};
    vr = '{8'hE0, 8'h01, 8'h7E};

    repeat (5) @(negedge clk);
    check("reset_pins", {spi_sen, spi_sclk, spi_sdat, busy, done}, 5'b11000);
    check("reset_rdata", rdata, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3; i++) run_frame(va[i], vr[i]);

    repeat (50) @(negedge clk);
    check("rdata_hold", rdata, 8'h7E);

    // Reset 500 cycles into a frame.
    resp = 8'h99;
    pulse_start(8'h77);
    repeat (500) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_pins", {spi_sen, spi_sclk, busy, done}, 4'b1100);
    check("midreset_rdata", rdata, 8'h00);
    q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_frame(8'h41, 8'hC0);

    // Extra start pulses inside a running frame must be ignored.
    resp = 8'h3C;
    q.push_back('{8'h3C, exp_addr(8'h5A)});
    nd = n_done;
    pulse_start(8'h5A);
    repeat (9) @(negedge clk);
    pulse_start(8'h11);
    repeat (189) @(negedge clk);
    pulse_start(8'h22);
    wait_done(nd, UNITS * HD + 200);
    repeat (UNITS * HD + 100) @(negedge clk);
    check("single_done", n_done - nd, 1);
    check("busy_idle", busy, 1'b0);

    // Minimum divider instance.
    resp2 = 8'h03;
    q2.push_back('{8'h03, exp_addr(8'h25)});
    nd = n_done2;
    @(negedge clk);
    start2 = 1'b1;
    addr2  = 8'h25;
    @(negedge clk);
    start2 = 1'b0;
    addr2  = 8'h00;
    k = 0;
    while (n_done2 == nd && k < UNITS * HD2 + 50) begin
      @(posedge clk);
      k++;
    end
    if (n_done2 == nd) begin
      n_total++;
      $display("FAIL hd2_done_timeout: got no done within %0d cycles, expected one", UNITS * HD2 + 50);
    end
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
